// File: rtl/image_stream_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// image_stream_pkg - shared state type and default geometry for the line feeder
// Rev 1.0
// ----------------------------------------------------------------------------
package image_stream_pkg;

  localparam int PIXEL_W        = 8;
  localparam int DEFAULT_LINE_W = 512;
  localparam int DEFAULT_IMG_H  = 512;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFILL   = 3'd1,
    WAIT_LINE = 3'd2,
    SEND_LINE = 3'd3,
    SEND_PAD  = 3'd4,
    DONE      = 3'd5
  } feeder_state_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intr_credit_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intr_credit_counter - interrupt edge detect with saturating line-slot credits
// Rev 1.0
// ----------------------------------------------------------------------------
module intr_credit_counter #(
  parameter int CREDIT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic intr_in,
  input  logic consume,
  output logic has_credit,
  output logic overflow
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  logic                intr_d;
  logic [CREDIT_W-1:0] credit;
  logic                intr_edge;
  logic                take_credit;

  assign intr_edge   = intr_in & ~intr_d & enable;
  assign has_credit  = (credit != '0);
  assign take_credit = consume & has_credit;

  // A simultaneous edge and consume leaves the count untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_d   <= 1'b0;
      credit   <= '0;
      overflow <= 1'b0;
    end else begin
      intr_d <= intr_in;
      if (clear) begin
        credit   <= '0;
        overflow <= 1'b0;
      end else if (intr_edge && !take_credit) begin
        if (credit == CREDIT_MAX) begin
          overflow <= 1'b1;
        end else begin
          credit <= credit + 1'b1;
        end
      end else if (!intr_edge && take_credit) begin
        credit <= credit - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_line_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// image_line_feeder - releases upstream pixels to the filter one line per credit
// Rev 1.0
// ----------------------------------------------------------------------------
module image_line_feeder
  import image_stream_pkg::*;
#(
  parameter int LINE_W        = DEFAULT_LINE_W,
  parameter int IMG_H         = DEFAULT_IMG_H,
  parameter int PREFILL_LINES = 4,
  parameter int PAD_LINES     = 2,
  parameter int CREDIT_W      = 3
) (
  input  logic               axi_clk,
  input  logic               axi_reset,
  input  logic               start,
  input  logic [PIXEL_W-1:0] s_pixel_data,
  input  logic               s_pixel_valid,
  output logic               s_pixel_ready,
  input  logic               intr_in,
  output logic [PIXEL_W-1:0] m_pixel_data,
  output logic               m_pixel_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               credit_overflow
);

  localparam int PIX_CW  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int LINE_CW = $clog2(IMG_H + 1);
  localparam int PAD_CW  = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;

  localparam logic [PIX_CW-1:0]  PIX_LAST    = PIX_CW'(LINE_W - 1);
  localparam logic [LINE_CW-1:0] IMG_END     = LINE_CW'(IMG_H);
  localparam logic [LINE_CW-1:0] PREFILL_END = LINE_CW'(min_int(PREFILL_LINES, IMG_H));
  localparam logic [PAD_CW-1:0]  PAD_END     = PAD_CW'(PAD_LINES);

  feeder_state_t      state;
  logic [PIX_CW-1:0]  pix_cnt;
  logic [LINE_CW-1:0] line_cnt;
  logic [PAD_CW-1:0]  pad_cnt;

  logic has_credit;
  logic consume;
  logic start_accept;
  logic take;
  logic pix_last;
  logic img_done;
  logic pad_done;

  assign s_pixel_ready = (state == PREFILL) || (state == SEND_LINE);
  assign take          = s_pixel_valid & s_pixel_ready;
  assign pix_last      = (pix_cnt == PIX_LAST);
  assign img_done      = (line_cnt == IMG_END);
  assign pad_done      = (pad_cnt == PAD_END);
  assign start_accept  = (state == IDLE) & start;
  assign consume       = (state == WAIT_LINE) & has_credit & (~img_done | ~pad_done);

  intr_credit_counter #(
    .CREDIT_W (CREDIT_W)
  ) u_credit (
    .clk        (axi_clk),
    .rst        (axi_reset),
    .clear      (start_accept),
    .enable     (state != IDLE),
    .intr_in    (intr_in),
    .consume    (consume),
    .has_credit (has_credit),
    .overflow   (credit_overflow)
  );

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      line_cnt      <= '0;
      pad_cnt       <= '0;
      m_pixel_data  <= '0;
      m_pixel_valid <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      m_pixel_valid <= 1'b0;
      frame_done    <= 1'b0;
      if (take) begin
        m_pixel_valid <= 1'b1;
        m_pixel_data  <= s_pixel_data;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= PREFILL;
            pix_cnt  <= '0;
            line_cnt <= '0;
            pad_cnt  <= '0;
            busy     <= 1'b1;
          end
        end

        // Prefill lines and credited lines share the transfer path; only the exit differs.
        PREFILL, SEND_LINE: begin
          if (take) begin
            pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            if (pix_last) begin
              line_cnt <= line_cnt + 1'b1;
              if ((state == SEND_LINE) || ((line_cnt + 1'b1) == PREFILL_END)) begin
                state <= WAIT_LINE;
              end
            end
          end
        end

        WAIT_LINE: begin
          if (consume) begin
            state <= img_done ? SEND_PAD : SEND_LINE;
          end else if (img_done && pad_done) begin
            state      <= DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end

        SEND_PAD: begin
          m_pixel_valid <= 1'b1;
          m_pixel_data  <= '0;
          pix_cnt       <= pix_last ? '0 : pix_cnt + 1'b1;
          if (pix_last) begin
            pad_cnt <= pad_cnt + 1'b1;
            state   <= WAIT_LINE;
          end
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_line_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_image_line_feeder - scoreboard bench: prefill, credited lines, pads, reset
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_image_line_feeder;

  localparam int LINE_W        = 8;
  localparam int IMG_H         = 8;
  localparam int PREFILL_LINES = 4;
  localparam int PAD_LINES     = 2;
  localparam int CREDIT_W      = 3;

  logic       axi_clk = 1'b0;
  logic       axi_reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] s_pixel_data = 8'h00;
  logic       s_pixel_valid = 1'b0;
  logic       s_pixel_ready;
  logic       intr_in = 1'b0;
  logic [7:0] m_pixel_data;
  logic       m_pixel_valid;
  logic       busy;
  logic       frame_done;
  logic       credit_overflow;

  image_line_feeder #(
    .LINE_W        (LINE_W),
    .IMG_H         (IMG_H),
    .PREFILL_LINES (PREFILL_LINES),
    .PAD_LINES     (PAD_LINES),
    .CREDIT_W      (CREDIT_W)
  ) dut (
    .axi_clk         (axi_clk),
    .axi_reset       (axi_reset),
    .start           (start),
    .s_pixel_data    (s_pixel_data),
    .s_pixel_valid   (s_pixel_valid),
    .s_pixel_ready   (s_pixel_ready),
    .intr_in         (intr_in),
    .m_pixel_data    (m_pixel_data),
    .m_pixel_valid   (m_pixel_valid),
    .busy            (busy),
    .frame_done      (frame_done),
    .credit_overflow (credit_overflow)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   hs_cnt = 0;
  int   beats = 0;
  int   done_cnt = 0;
  logic src_en = 1'b0;
  logic src_rand = 1'b0;
  logic [7:0] next_pix = 8'h01;

  always @(posedge axi_clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Upstream source: every accepted handshake becomes an expected beat one cycle later.
  initial begin
    forever begin
      @(negedge axi_clk);
      if (s_pixel_valid && s_pixel_ready && !axi_reset) begin
        exp_q.push_back('{s_pixel_data, cycle});
        next_pix++;
        hs_cnt++;
      end
      @(posedge axi_clk);
      #1;
      s_pixel_valid = src_en && (!src_rand || ($urandom_range(0, 1) == 1));
      s_pixel_data  = next_pix;
    end
  end

  // Monitor: pops the scoreboard on every output beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge axi_clk);
      if (m_pixel_valid) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_beat: data %0d with nothing expected", m_pixel_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", int'(m_pixel_data), int'(e.data));
          if (e.cyc >= 0) chk("beat_latency", cycle, e.cyc + 1);
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("busy_low_at_done", int'(busy), 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge axi_clk); #1; start = 1'b1;
    @(posedge axi_clk); #1; start = 1'b0;
  endtask

  task automatic pulse_intr();
    @(posedge axi_clk); #1; intr_in = 1'b1;
    @(posedge axi_clk); #1; intr_in = 1'b0;
  endtask

  task automatic push_pad_line();
    for (int i = 0; i < LINE_W; i++) exp_q.push_back('{8'h00, -1});
  endtask

  task automatic wait_hs(input string name, input int base, input int target, input int budget);
    int n = 0;
    while ((hs_cnt - base) < target && n < budget) begin
      @(posedge axi_clk); #2;
      n++;
    end
    chk(name, hs_cnt - base, target);
  endtask

  task automatic wait_done(input string name, input int base, input int budget);
    int n = 0;
    while ((done_cnt - base) < 1 && n < budget) begin
      @(posedge axi_clk); #2;
      n++;
    end
    chk(name, done_cnt - base, 1);
  endtask

  task automatic check_quiet_outputs(input string tag);
    chk({tag, "_m_valid"}, int'(m_pixel_valid), 0);
    chk({tag, "_m_data"}, int'(m_pixel_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_s_ready"}, int'(s_pixel_ready), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_overflow"}, int'(credit_overflow), 0);
  endtask

  initial begin
    int hs_base, beat_base, done_base;
    logic ready_seen;

    tick(3);
    check_quiet_outputs("reset");
    axi_reset = 1'b0;
    tick(2);

    // Frame 1: steady upstream, prefill then credited lines then pads.
    src_en = 1'b1; src_rand = 1'b0;
    hs_base = hs_cnt; beat_base = beats; done_base = done_cnt;
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    wait_hs("prefill_handshakes", hs_base, 32, 200);
    ready_seen = 1'b0;
    repeat (20) begin
      @(negedge axi_clk);
      if (s_pixel_ready) ready_seen = 1'b1;
    end
    chk("ready_low_after_prefill", int'(ready_seen), 0);
    chk("prefill_beats", beats - beat_base, 32);
    for (int i = 0; i < 4; i++) begin
      pulse_intr();
      tick(20);
      chk("credited_line_beats", beats - beat_base, 40 + 8 * i);
    end
    ready_seen = 1'b0;
    repeat (20) begin
      @(negedge axi_clk);
      if (s_pixel_ready) ready_seen = 1'b1;
    end
    chk("ready_low_after_image", int'(ready_seen), 0);
    chk("image_handshakes", hs_cnt - hs_base, 64);
    for (int i = 0; i < PAD_LINES; i++) begin
      push_pad_line();
      pulse_intr();
      tick(20);
    end
    chk("frame1_done_pulses", done_cnt - done_base, 1);
    chk("frame1_total_beats", beats - beat_base, 80);
    chk("frame1_busy_end", int'(busy), 0);

    // Frame A: random upstream gaps, three credits banked during prefill.
    src_rand = 1'b1;
    hs_base = hs_cnt; beat_base = beats; done_base = done_cnt;
    pulse_start();
    repeat (3) pulse_intr();
    wait_hs("banked_lines", hs_base, 56, 1000);
    tick(30);
    chk("stall_without_credit", hs_cnt - hs_base, 56);
    chk("banked_beats", beats - beat_base, 56);
    pulse_intr();
    wait_hs("last_image_line", hs_base, 64, 400);
    push_pad_line();
    pulse_intr();
    tick(20);
    push_pad_line();
    pulse_intr();
    wait_done("frameA_done", done_base, 60);
    tick(5);
    chk("frameA_total_beats", beats - beat_base, 80);
    chk("frameA_no_overflow", int'(credit_overflow), 0);

    // Frame B: eight edges during prefill saturate the credits and flag overflow.
    hs_base = hs_cnt; beat_base = beats; done_base = done_cnt;
    pulse_start();
    repeat (8) pulse_intr();
    chk("overflow_set", int'(credit_overflow), 1);
    wait_hs("frameB_image", hs_base, 64, 1000);
    push_pad_line();
    push_pad_line();
    wait_done("frameB_done", done_base, 100);
    tick(5);
    chk("frameB_total_beats", beats - beat_base, 80);
    chk("frameB_single_done", done_cnt - done_base, 1);
    chk("overflow_sticky", int'(credit_overflow), 1);

    // Frame C: reset in the middle of a credited line with one credit still pending.
    src_rand = 1'b0;
    hs_base = hs_cnt;
    pulse_start();
    chk("overflow_cleared_by_start", int'(credit_overflow), 0);
    wait_hs("frameC_prefill", hs_base, 32, 200);
    pulse_intr();
    pulse_intr();
    wait_hs("frameC_pixel5", hs_base, 37, 100);
    axi_reset = 1'b1;
    #1;
    check_quiet_outputs("midline_reset");
    exp_q.delete();
    beat_base = beats;
    tick(3);
    axi_reset = 1'b0;
    tick(20);
    chk("no_beats_before_start", beats - beat_base, 0);

    hs_base = hs_cnt; beat_base = beats;
    pulse_start();
    wait_hs("restart_prefill", hs_base, 32, 200);
    tick(40);
    chk("restart_credits_cleared", hs_cnt - hs_base, 32);
    chk("restart_beats", beats - beat_base, 32);
    chk("restart_busy", int'(busy), 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", chk_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
